rgmii_rx: RTL and testbench

RGMII_RX -- requirements
Module: rgmii_rx

---
 rtl/rgmii_rx_pkg.sv | 53 +++++
 rtl/rgmii_rx_iddr.sv | 84 ++++++++
 rtl/rgmii_rx.sv | 219 +++++++++++++++++++++
 tb/tb_rgmii_rx.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_rx_pkg.sv
// Shared definitions for the RGMII receive path: frame FSM encoding,
// preamble/SFD byte values, in-band status speed codes and filter depth.
package rgmii_rx_pkg;

    // Frame tracking states, evaluated on the reassembled GMII byte stream.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DISCARD  = 2'd3
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // In-band status speed codes carried in rxd[2:1] during inter-frame gaps.
    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;
    localparam logic [1:0] SPEED_RSVD  = 2'b11;

    // Number of identical consecutive qualifying candidates before the
    // status outputs follow a new value.
    localparam int STATUS_STABLE_CNT = 4;

    // Payload length counter saturates here instead of wrapping.
    localparam logic [15:0] FRAME_LEN_MAX = 16'hFFFF;

    // In-band status nibble layout: {duplex, speed[1:0], link}.
    typedef struct packed {
        logic       duplex;
        logic [1:0] speed;
        logic       link;
    } inband_status_t;

    // Reinterpret a status nibble as its named fields.
    function automatic inband_status_t decode_status(input logic [3:0] nib);
        return inband_status_t'(nib);
    endfunction

    // Only the three defined speed codes are accepted as status.
    function automatic logic speed_is_valid(input logic [1:0] speed);
        logic ok;
        ok = 1'b0;
        case (speed)
            SPEED_10M, SPEED_100M, SPEED_1000M: ok = 1'b1;
            SPEED_RSVD:                         ok = 1'b0;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rgmii_rx_iddr.sv
// One-bit DDR input capture. The rising-edge sample and the falling-edge
// sample of the same clock period are presented together on the following
// rising edge (same-edge pipelined arrangement), so downstream logic only
// ever sees a rising-edge-aligned pair.
module rgmii_rx_iddr #(
    parameter int USE_VENDOR_IDDR = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q_rise,
    output logic o_q_fall
);

    generate
        if (USE_VENDOR_IDDR != 0) begin : g_vendor
            // Pad flops are marked for I/O-cell placement so the tool packs
            // them into the device input DDR register pair; the retiming
            // flops behind them complete the same-edge pipelined form.
            (* IOB = "TRUE" *) logic r_pad_rise;
            (* IOB = "TRUE" *) logic r_pad_fall;
            logic r_q_rise;
            logic r_q_fall;

            // Rising-edge pad capture.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) r_pad_rise <= 1'b0;
                else       r_pad_rise <= i_d;
            end

            // Falling-edge pad capture.
            always_ff @(negedge i_clk or posedge i_rst) begin
                if (i_rst) r_pad_fall <= 1'b0;
                else       r_pad_fall <= i_d;
            end

            // Present both samples of one period together on the next rising edge.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_q_rise <= 1'b0;
                    r_q_fall <= 1'b0;
                end else begin
                    r_q_rise <= r_pad_rise;
                    r_q_fall <= r_pad_fall;
                end
            end

            assign o_q_rise = r_q_rise;
            assign o_q_fall = r_q_fall;
        end else begin : g_behav
            logic r_rise;
            logic r_fall;
            logic r_q_rise;
            logic r_q_fall;

            // Behavioural rising-edge sample.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) r_rise <= 1'b0;
                else       r_rise <= i_d;
            end

            // Behavioural falling-edge sample.
            always_ff @(negedge i_clk or posedge i_rst) begin
                if (i_rst) r_fall <= 1'b0;
                else       r_fall <= i_d;
            end

            // Realign the pair onto the rising edge.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_q_rise <= 1'b0;
                    r_q_fall <= 1'b0;
                end else begin
                    r_q_rise <= r_rise;
                    r_q_fall <= r_fall;
                end
            end

            assign o_q_rise = r_q_rise;
            assign o_q_fall = r_q_fall;
        end
    endgenerate

endmodule

// File: rtl/rgmii_rx.sv
// RGMII receiver: DDR capture to GMII byte stream, in-band link status
// filtering and a small frame tracker reporting SFD, payload and length.
// Everything runs on the received clock; reset assertion is asynchronous
// and its release is assumed already synchronized to gmii_rx_clk.
module rgmii_rx
    import rgmii_rx_pkg::*;
#(
    parameter int USE_VENDOR_IDDR = 1
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        rgmii_rx_ctl,
    input  logic [3:0]  rgmii_rxd,
    output logic [7:0]  gmii_rxd,
    output logic        gmii_rx_dv,
    output logic        gmii_rx_er,
    output logic        payload_valid,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_len,
    output logic        frame_err,
    output logic        link_up,
    output logic [1:0]  link_speed,
    output logic        full_duplex
);

    // Counter value reached on the last of the required identical candidates.
    localparam logic [1:0] STATUS_CNT_LAST = 2'(STATUS_STABLE_CNT - 1);

    // Bit 4 carries ctl, bits 3:0 carry rxd through the capture cells.
    logic [4:0] w_pins;
    logic [4:0] w_q_rise;
    logic [4:0] w_q_fall;

    assign w_pins = {rgmii_rx_ctl, rgmii_rxd};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_iddr
            rgmii_rx_iddr #(
                .USE_VENDOR_IDDR (USE_VENDOR_IDDR)
            ) u_iddr (
                .i_clk    (gmii_rx_clk),
                .i_rst    (rst),
                .i_d      (w_pins[gi]),
                .o_q_rise (w_q_rise[gi]),
                .o_q_fall (w_q_fall[gi])
            );
        end
    endgenerate

    // Aligned pair of one rxc period.
    logic       w_ctl_r;
    logic       w_ctl_f;
    logic [3:0] w_rxd_r;
    logic [3:0] w_rxd_f;
    logic [7:0] w_byte;
    logic       w_dv;
    logic       w_er;

    assign w_ctl_r = w_q_rise[4];
    assign w_ctl_f = w_q_fall[4];
    assign w_rxd_r = w_q_rise[3:0];
    assign w_rxd_f = w_q_fall[3:0];
    assign w_byte  = {w_rxd_f, w_rxd_r};
    assign w_dv    = w_ctl_r;
    assign w_er    = w_ctl_r ^ w_ctl_f;

    // ------------------------------------------------------------------
    // GMII output registers
    // ------------------------------------------------------------------
    logic [7:0] r_gmii_rxd;
    logic       r_gmii_rx_dv;
    logic       r_gmii_rx_er;

    // Register the reassembled byte and the decoded DV/ER.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            r_gmii_rxd   <= 8'h00;
            r_gmii_rx_dv <= 1'b0;
            r_gmii_rx_er <= 1'b0;
        end else begin
            r_gmii_rxd   <= w_byte;
            r_gmii_rx_dv <= w_dv;
            r_gmii_rx_er <= w_er;
        end
    end

    // ------------------------------------------------------------------
    // In-band status filter
    // ------------------------------------------------------------------
    // A candidate exists only in a clean inter-frame gap where both nibbles
    // repeat the same status code.
    logic           w_status_qualify;
    inband_status_t w_cand;
    logic [1:0]     w_cnt_inc;

    inband_status_t r_cand;
    logic [1:0]     r_stable_cnt;
    logic           r_link_up;
    logic [1:0]     r_link_speed;
    logic           r_full_duplex;

    assign w_status_qualify = !w_ctl_r && !w_ctl_f && (w_rxd_r == w_rxd_f);
    assign w_cand           = decode_status(w_rxd_r);
    assign w_cnt_inc        = (r_stable_cnt == 2'd3) ? 2'd3 : (r_stable_cnt + 2'd1);

    // Track how long the same candidate has repeated and commit it once stable.
    // A reserved speed code is stored as the candidate so the next valid code
    // always compares unequal and starts a fresh run.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            r_cand        <= '0;
            r_stable_cnt  <= 2'd0;
            r_link_up     <= 1'b0;
            r_link_speed  <= SPEED_10M;
            r_full_duplex <= 1'b0;
        end else if (w_status_qualify) begin
            if (!speed_is_valid(w_cand.speed) || (w_cand != r_cand)) begin
                r_cand       <= w_cand;
                r_stable_cnt <= 2'd0;
            end else begin
                r_stable_cnt <= w_cnt_inc;
                if (w_cnt_inc == STATUS_CNT_LAST) begin
                    r_link_up     <= w_cand.link;
                    r_link_speed  <= w_cand.speed;
                    r_full_duplex <= w_cand.duplex;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame tracker
    // ------------------------------------------------------------------
    // The FSM decodes the aligned pair in parallel with the GMII output
    // registers, so its registered pulses line up with the byte they refer
    // to on gmii_rxd.
    rx_state_t   r_state;
    logic        r_payload_valid;
    logic        r_frame_start;
    logic        r_frame_done;
    logic [15:0] r_frame_len;
    logic        r_frame_err;

    // Frame FSM with registered pulse, length and error outputs.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_payload_valid <= 1'b0;
            r_frame_start   <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_len     <= 16'h0000;
            r_frame_err     <= 1'b0;
        end else begin
            r_payload_valid <= 1'b0;
            r_frame_start   <= 1'b0;
            r_frame_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_dv) begin
                        r_state <= (w_byte == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DISCARD;
                    end
                end
                ST_PREAMBLE: begin
                    if (!w_dv) begin
                        // Preamble with no SFD is not a frame: no completion pulse.
                        r_state <= ST_IDLE;
                    end else if (w_byte == PREAMBLE_BYTE) begin
                        r_state <= ST_PREAMBLE;
                    end else if (w_byte == SFD_BYTE) begin
                        r_state       <= ST_DATA;
                        r_frame_start <= 1'b1;
                        r_frame_len   <= 16'h0000;
                        r_frame_err   <= 1'b0;
                    end else begin
                        r_state <= ST_DISCARD;
                    end
                end
                ST_DATA: begin
                    if (w_dv) begin
                        r_payload_valid <= 1'b1;
                        if (r_frame_len != FRAME_LEN_MAX) begin
                            r_frame_len <= r_frame_len + 16'd1;
                        end
                        if (w_er) begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        // Any DV gap ends the frame; length/error hold until the next SFD.
                        r_state      <= ST_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (!w_dv) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gmii_rxd      = r_gmii_rxd;
    assign gmii_rx_dv    = r_gmii_rx_dv;
    assign gmii_rx_er    = r_gmii_rx_er;
    assign payload_valid = r_payload_valid;
    assign frame_start   = r_frame_start;
    assign frame_done    = r_frame_done;
    assign frame_len     = r_frame_len;
    assign frame_err     = r_frame_err;
    assign link_up       = r_link_up;
    assign link_speed    = r_link_speed;
    assign full_duplex   = r_full_duplex;

endmodule

// File: tb/tb_rgmii_rx.sv
// Bench for rgmii_rx: directed and randomized RGMII pin traffic, a
// stream-level reference model checked every cycle, plus literal checks
// on the key scenarios.
module tb_rgmii_rx;

    logic        gmii_rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rgmii_rx_ctl = 1'b0;
    logic [3:0]  rgmii_rxd = 4'h0;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        payload_valid;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] frame_len;
    logic        frame_err;
    logic        link_up;
    logic [1:0]  link_speed;
    logic        full_duplex;

    always #4 gmii_rx_clk = ~gmii_rx_clk;

    rgmii_rx #(
        .USE_VENDOR_IDDR (0)
    ) dut (
        .gmii_rx_clk   (gmii_rx_clk),
        .rst           (rst),
        .rgmii_rx_ctl  (rgmii_rx_ctl),
        .rgmii_rxd     (rgmii_rxd),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .payload_valid (payload_valid),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .frame_len     (frame_len),
        .frame_err     (frame_err),
        .link_up       (link_up),
        .link_speed    (link_speed),
        .full_duplex   (full_duplex)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One rxc period of pin values: rise ctl/nibble, fall ctl/nibble.
    typedef struct packed {
        logic       cr;
        logic [3:0] dr;
        logic       cf;
        logic [3:0] df;
    } pair_t;

    pair_t cur = '0;
    pair_t pipe[$];

    // ---------------- reference model state ----------------
    int   m_last;     // last accepted status candidate, -1 = none
    int   m_run;      // consecutive repeats of m_last
    logic m_link;
    logic [1:0] m_speed;
    logic m_dup;
    int   m_n55;      // leading 0x55 bytes in the current DV burst
    bit   m_bad;      // burst prefix is not preamble-then-SFD
    bit   m_framed;   // SFD seen in the current burst
    int   m_len;
    bit   m_err;

    logic [7:0]  e_rxd;
    logic        e_dv, e_er, e_start, e_pv, e_done, e_ferr, e_link, e_dup;
    logic [15:0] e_len;
    logic [1:0]  e_speed;

    // Observations for literal scenario checks.
    int o_start, o_pv, o_done, o_er;
    logic [15:0] o_len;
    logic        o_err;

    task automatic model_reset();
        m_last = -1; m_run = 0;
        m_link = 1'b0; m_speed = 2'b00; m_dup = 1'b0;
        m_n55 = 0; m_bad = 1'b0; m_framed = 1'b0;
        m_len = 0; m_err = 1'b0;
    endtask

    // Expected outputs for the pair that reached the output registers.
    task automatic model_step(input pair_t p);
        int cand;
        logic [7:0] bv;
        logic dv, er;
        dv = p.cr;
        er = p.cr ^ p.cf;
        bv = {p.df, p.dr};
        e_rxd = bv; e_dv = dv; e_er = er;
        e_start = 1'b0; e_pv = 1'b0; e_done = 1'b0;

        // Status: same nibble on both edges of an idle period, 4 in a row.
        if (!p.cr && !p.cf && (p.dr == p.df)) begin
            cand = int'(p.dr);
            if (((cand >> 1) & 3) == 3) begin
                m_last = -1; m_run = 0;
            end else if (cand == m_last) begin
                m_run++;
            end else begin
                m_last = cand; m_run = 1;
            end
            if (m_run >= 4) begin
                m_link  = cand[0];
                m_speed = cand[2:1];
                m_dup   = cand[3];
            end
        end

        // Frame: a DV burst is a frame if it starts 0x55^n (n>=1) then 0xD5.
        if (dv) begin
            if (m_framed) begin
                e_pv = 1'b1;
                m_len++;
                if (er) m_err = 1'b1;
            end else if (!m_bad) begin
                if (bv == 8'h55) m_n55++;
                else if (bv == 8'hD5 && m_n55 > 0) begin
                    m_framed = 1'b1; e_start = 1'b1; m_len = 0; m_err = 1'b0;
                end else m_bad = 1'b1;
            end
        end else begin
            e_done = m_framed;
            m_framed = 1'b0; m_bad = 1'b0; m_n55 = 0;
        end
        e_len   = (m_len > 65535) ? 16'hFFFF : 16'(m_len);
        e_ferr  = m_err;
        e_link  = m_link;
        e_speed = m_speed;
        e_dup   = m_dup;
    endtask

    // Per-cycle compare: outputs at this falling edge reflect the pair
    // driven two rising edges earlier.
    always @(negedge gmii_rx_clk) begin
        pair_t p;
        if (rst) begin
            model_reset();
            pipe.delete();
            pipe.push_back('0);
            pipe.push_back('0);
            e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0; e_start = 1'b0; e_pv = 1'b0;
            e_done = 1'b0; e_len = 16'h0; e_ferr = 1'b0; e_link = 1'b0;
            e_speed = 2'b00; e_dup = 1'b0;
        end else begin
            pipe.push_back(cur);
            p = pipe.pop_front();
            model_step(p);
            if (frame_start) o_start++;
            if (payload_valid) o_pv++;
            if (payload_valid && gmii_rx_er) o_er++;
            if (frame_done) begin o_done++; o_len = frame_len; o_err = frame_err; end
        end
        check("gmii_rxd",      32'(gmii_rxd),      32'(e_rxd));
        check("gmii_rx_dv",    32'(gmii_rx_dv),    32'(e_dv));
        check("gmii_rx_er",    32'(gmii_rx_er),    32'(e_er));
        check("frame_start",   32'(frame_start),   32'(e_start));
        check("payload_valid", 32'(payload_valid), 32'(e_pv));
        check("frame_done",    32'(frame_done),    32'(e_done));
        check("frame_len",     32'(frame_len),     32'(e_len));
        check("frame_err",     32'(frame_err),     32'(e_ferr));
        check("link_up",       32'(link_up),       32'(e_link));
        check("link_speed",    32'(link_speed),    32'(e_speed));
        check("full_duplex",   32'(full_duplex),   32'(e_dup));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic cr, input logic [3:0] dr, input logic cf, input logic [3:0] df);
        cur = {cr, dr, cf, df};
        rgmii_rx_ctl = cr;
        rgmii_rxd    = dr;
        @(posedge gmii_rx_clk);
        #1;
        rgmii_rx_ctl = cf;
        rgmii_rxd    = df;
        @(negedge gmii_rx_clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] nib, input int n);
        repeat (n) drive(1'b0, nib, 1'b0, nib);
    endtask

    // False-carrier style gap cycles: dv=0 but not a status candidate.
    task automatic noq(input int n);
        repeat (n) drive(1'b0, 4'h0, 1'b1, 4'h0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit er);
        drive(1'b1, b[3:0], er ? 1'b0 : 1'b1, b[7:4]);
    endtask

    task automatic clear_obs();
        o_start = 0; o_pv = 0; o_done = 0; o_er = 0;
        o_len = 16'h0; o_err = 1'b0;
    endtask

    task automatic send_frame(input int npre, input logic [7:0] sfd, input int plen,
                              input int err_idx, input int rst_at, input bit rnd);
        for (int i = 0; i < npre; i++) send_byte(8'h55, 1'b0);
        send_byte(sfd, 1'b0);
        for (int i = 0; i < plen; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_now_rxd", 32'(gmii_rxd), 32'h0);
                check("rst_now_dv", 32'(gmii_rx_dv), 32'h0);
                check("rst_now_pv", 32'(payload_valid), 32'h0);
                check("rst_now_len", 32'(frame_len), 32'h0);
                check("rst_now_link", 32'(link_up), 32'h0);
            end
            if (rst_at >= 0 && i == rst_at + 2) rst = 1'b0;
            send_byte(rnd ? 8'($urandom) : 8'(i), i == err_idx);
        end
        idle(4'hB, 4);
        $display("frame npre=%0d sfd=%02h plen=%0d err_idx=%0d rst_at=%0d -> starts=%0d dones=%0d len=%0d err=%0b",
                 npre, sfd, plen, err_idx, rst_at, o_start, o_done, o_len, o_err);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        idle(4'h0, 3);
        check("reset_rxd", 32'(gmii_rxd), 32'h0);
        check("reset_link", 32'(link_up), 32'h0);
        check("reset_len", 32'(frame_len), 32'h0);
        rst = 1'b0;
        idle(4'h0, 6);

        // Status: 3 repeats then a different code must not update.
        idle(4'hB, 3); idle(4'h0, 1); noq(3);
        check("status_3x_link", 32'(link_up), 32'h0);
        check("status_3x_speed", 32'(link_speed), 32'h0);
        $display("status 3x0xB then 0x0 -> link=%0b speed=%0b dup=%0b", link_up, link_speed, full_duplex);
        // 4 repeats of 0xB: link up, 100M, full duplex.
        idle(4'hB, 4); noq(3);
        check("status_4x_link", 32'(link_up), 32'h1);
        check("status_4x_speed", 32'(link_speed), 32'h1);
        check("status_4x_dup", 32'(full_duplex), 32'h1);
        $display("status 4x0xB -> link=%0b speed=%0b dup=%0b", link_up, link_speed, full_duplex);
        // Reserved speed code 11 is ignored.
        idle(4'h7, 6); noq(3);
        check("status_rsvd_link", 32'(link_up), 32'h1);
        check("status_rsvd_speed", 32'(link_speed), 32'h1);
        check("status_rsvd_dup", 32'(full_duplex), 32'h1);
        $display("status 6x0x7 -> link=%0b speed=%0b dup=%0b", link_up, link_speed, full_duplex);
        idle(4'hB, 4);

        // Clean 64-byte frame.
        clear_obs();
        send_frame(7, 8'hD5, 64, -1, -1, 1'b0);
        check("clean_starts", 32'(o_start), 32'd1);
        check("clean_pv", 32'(o_pv), 32'd64);
        check("clean_dones", 32'(o_done), 32'd1);
        check("clean_len", 32'(o_len), 32'd64);
        check("clean_err", 32'(o_err), 32'd0);

        // Error on payload byte 10.
        clear_obs();
        send_frame(7, 8'hD5, 64, 10, -1, 1'b0);
        check("err_er_cycles", 32'(o_er), 32'd1);
        check("err_flag", 32'(o_err), 32'd1);
        check("err_len", 32'(o_len), 32'd64);

        // Bad preamble, then preamble-only burst.
        clear_obs();
        send_frame(2, 8'hAA, 10, -1, -1, 1'b0);
        check("discard_starts", 32'(o_start), 32'd0);
        check("discard_dones", 32'(o_done), 32'd0);
        clear_obs();
        send_frame(2, 8'h55, 0, -1, -1, 1'b0);
        check("preonly_starts", 32'(o_start), 32'd0);
        check("preonly_dones", 32'(o_done), 32'd0);

        // Reset at payload byte 20, then a clean frame.
        clear_obs();
        send_frame(7, 8'hD5, 64, -1, 20, 1'b0);
        check("rstmid_dones", 32'(o_done), 32'd0);
        clear_obs();
        send_frame(7, 8'hD5, 64, -1, -1, 1'b0);
        check("after_rst_dones", 32'(o_done), 32'd1);
        check("after_rst_len", 32'(o_len), 32'd64);

        // Zero-length frame.
        clear_obs();
        send_frame(3, 8'hD5, 0, -1, -1, 1'b0);
        check("zero_dones", 32'(o_done), 32'd1);
        check("zero_len", 32'(o_len), 32'd0);

        // Randomized mix, checked by the per-cycle model.
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: begin
                    logic [3:0] nib;
                    int n;
                    nib = 4'($urandom);
                    n = int'($urandom_range(1, 6));
                    idle(nib, n);
                    $display("idle nib=%0h x%0d", nib, n);
                end
                1: begin
                    int npre, plen, eidx;
                    logic [7:0] sfd;
                    npre = int'($urandom_range(0, 8));
                    sfd  = ($urandom_range(0, 3) != 0) ? 8'hD5 : 8'($urandom);
                    plen = int'($urandom_range(0, 40));
                    eidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
                    clear_obs();
                    send_frame(npre, sfd, plen, eidx, -1, 1'b1);
                end
                2: begin
                    int n;
                    n = int'($urandom_range(1, 5));
                    for (int k = 0; k < n; k++)
                        drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
                    $display("noise pairs x%0d", n);
                end
                default: begin
                    noq(2);
                    $display("gap pairs x2");
                end
            endcase
        end
        idle(4'hB, 4);

        // Length saturation.
        clear_obs();
        send_frame(7, 8'hD5, 70000, -1, -1, 1'b1);
        check("sat_dones", 32'(o_done), 32'd1);
        check("sat_len", 32'(o_len), 32'hFFFF);

        idle(4'hB, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
